// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD transfer engine and its access arbiter:
// engine mode encodings, default count width and the arbiter state encoding.
package lcd_pkg;

    localparam logic LCD_INIT  = 1'b1;
    localparam logic LCD_REF   = 1'b0;

    localparam int   LCD_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/lcd_access_arbiter_rr_picker.sv
// Combinational round-robin picker: scans the request vector starting at the
// pointer index, wrapping around, and returns the first requester one-hot.
module rr_picker #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win
);

    always_comb begin
        int   idx;
        logic found;
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned and no latch is inferred.
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_access_arbiter.sv
// Grants the shared LCD transfer engine to one client at a time, issues a single
// start pulse with that client's descriptor and releases on finish or watchdog.
module lcd_access_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int CNT_W       = LCD_CNT_W,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_reg_sel,
    input  logic [NUM_REQ-1:0]       req_mode,
    input  logic [NUM_REQ-1:0]       req_db_sel,
    input  logic [NUM_REQ*CNT_W-1:0] req_cnt,
    input  logic                     lcd_finish,
    output logic                     lcd_enable,
    output logic                     lcd_reg_sel,
    output logic                     lcd_mode,
    output logic                     lcd_db_sel,
    output logic [CNT_W-1:0]         lcd_cnt,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     timeout_err,
    output logic                     busy,
    output logic                     init_done
);

    localparam int                 PTR_W     = $clog2(NUM_REQ);
    localparam int                 WD_W      = $clog2(TIMEOUT_CYC);
    localparam logic [PTR_W-1:0]   PTR_FIRST = PTR_W'(1);
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT_CYC - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                enable_q, enable_d;
    logic                timeout_q, timeout_d;
    logic                init_done_q, init_done_d;
    logic                reg_sel_q, reg_sel_d;
    logic                mode_q, mode_d;
    logic                db_sel_q, db_sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  rr_win;
    logic [NUM_REQ-1:0]  pick;
    logic [PTR_W-1:0]    pick_idx;

    // Client 0 never takes part in the rotation; it is handled by fixed priority.
    rr_picker #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .req (req & ~NUM_REQ'(1)),
        .ptr (ptr_q),
        .win (rr_win)
    );

    always_comb begin
        pick = '0;
        if (req[0]) begin
            pick[0] = 1'b1;
        end else if (init_done_q) begin
            pick = rr_win;
        end
    end

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        win_d       = win_q;
        ptr_d       = ptr_q;
        wd_d        = wd_q;
        enable_d    = 1'b0;
        timeout_d   = 1'b0;
        init_done_d = init_done_q;
        reg_sel_d   = reg_sel_q;
        mode_d      = mode_q;
        db_sel_d    = db_sel_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|pick) begin
                    gnt_d     = pick;
                    win_d     = pick_idx;
                    reg_sel_d = req_reg_sel[pick_idx];
                    mode_d    = req_mode[pick_idx];
                    db_sel_d  = req_db_sel[pick_idx];
                    cnt_d     = req_cnt[int'(pick_idx)*CNT_W +: CNT_W];
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                enable_d = 1'b1;
                wd_d     = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // A finish arriving on the last watchdog cycle still counts as success.
                if (lcd_finish) begin
                    done_d  = gnt_q;
                    state_d = ST_RELEASE;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RELEASE: begin
                gnt_d = '0;
                if (win_q != '0) begin
                    ptr_d = (win_q == PTR_LAST) ? PTR_FIRST : win_q + PTR_W'(1);
                end else if (done_q[0]) begin
                    init_done_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            win_q       <= '0;
            ptr_q       <= PTR_FIRST;
            wd_q        <= '0;
            enable_q    <= 1'b0;
            timeout_q   <= 1'b0;
            init_done_q <= 1'b0;
            reg_sel_q   <= 1'b0;
            mode_q      <= 1'b0;
            db_sel_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            win_q       <= win_d;
            ptr_q       <= ptr_d;
            wd_q        <= wd_d;
            enable_q    <= enable_d;
            timeout_q   <= timeout_d;
            init_done_q <= init_done_d;
            reg_sel_q   <= reg_sel_d;
            mode_q      <= mode_d;
            db_sel_q    <= db_sel_d;
            cnt_q       <= cnt_d;
        end
    end

    assign lcd_enable  = enable_q;
    assign lcd_reg_sel = reg_sel_q;
    assign lcd_mode    = mode_q;
    assign lcd_db_sel  = db_sel_q;
    assign lcd_cnt     = cnt_q;
    assign gnt         = gnt_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign init_done   = init_done_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_access_arbiter.sv
// Scoreboard bench for lcd_access_arbiter: expected grants are queued as requests
// are raised and checked by a monitor when the arbiter grants, finishes or aborts.
module tb_lcd_access_arbiter;

    localparam int NUM_REQ = 3;
    localparam int CNT_W   = 2;
    localparam int T       = 8;

    typedef struct {
        int client;
        bit tmo;
    } exp_t;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       req_reg_sel;
    logic [NUM_REQ-1:0]       req_mode;
    logic [NUM_REQ-1:0]       req_db_sel;
    logic [NUM_REQ*CNT_W-1:0] req_cnt;
    logic                     lcd_finish;
    logic                     lcd_enable;
    logic                     lcd_reg_sel;
    logic                     lcd_mode;
    logic                     lcd_db_sel;
    logic [CNT_W-1:0]         lcd_cnt;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     timeout_err;
    logic                     busy;
    logic                     init_done;

    // Per-client descriptors driven onto the request buses.
    logic [CNT_W-1:0] tb_cnt     [NUM_REQ] = '{2'd1, 2'd0, 2'd3};
    logic             tb_reg_sel [NUM_REQ] = '{1'b0, 1'b1, 1'b1};
    logic             tb_mode    [NUM_REQ] = '{1'b1, 1'b0, 1'b0};
    logic             tb_db_sel  [NUM_REQ] = '{1'b1, 1'b0, 1'b1};

    int   assertions = 0;
    int   failures   = 0;
    exp_t exp_q[$];
    exp_t cur;
    bit   cur_valid  = 1'b0;
    int   cyc = 0, grant_seen = 0, done_seen = 0, tmo_seen = 0, en_seen = 0;
    int   last_grant_cyc = 0, last_en_cyc = 0, last_done_cyc = 0, last_tmo_cyc = 0;
    int   grant_cyc_q[$];
    logic [NUM_REQ-1:0] prev_gnt = '0;
    logic               prev_en  = 1'b0;
    logic [NUM_REQ-1:0] exp_vec;

    int   fin_delay = -1;
    logic eng_fin   = 1'b0;
    logic man_fin   = 1'b0;
    assign lcd_finish = eng_fin | man_fin;

    lcd_access_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_reg_sel (req_reg_sel),
        .req_mode    (req_mode),
        .req_db_sel  (req_db_sel),
        .req_cnt     (req_cnt),
        .lcd_finish  (lcd_finish),
        .lcd_enable  (lcd_enable),
        .lcd_reg_sel (lcd_reg_sel),
        .lcd_mode    (lcd_mode),
        .lcd_db_sel  (lcd_db_sel),
        .lcd_cnt     (lcd_cnt),
        .gnt         (gnt),
        .done        (done),
        .timeout_err (timeout_err),
        .busy        (busy),
        .init_done   (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: answers each start pulse with lcd_finish fin_delay cycles later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (lcd_enable === 1'b1 && fin_delay >= 0) begin
                repeat (fin_delay) @(posedge clk);
                #1 eng_fin = 1'b1;
                @(posedge clk);
                #1 eng_fin = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each new grant and checks done/timeout pulses.
    always @(negedge clk) begin
        cyc++;
        if (rst_n !== 1'b1) begin
            prev_gnt  = '0;
            prev_en   = 1'b0;
            cur_valid = 1'b0;
        end else begin
            if (gnt !== '0 && prev_gnt === '0) begin
                grant_seen++;
                last_grant_cyc = cyc;
                grant_cyc_q.push_back(cyc);
                assertions++;
                if (exp_q.size() == 0) begin
                    failures++;
                    cur_valid = 1'b0;
                    $display("FAIL unexpected_grant: gnt=%b, none expected", gnt);
                end else begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1'b1;
                    exp_vec   = '0;
                    exp_vec[cur.client] = 1'b1;
                    if (gnt !== exp_vec || lcd_cnt !== tb_cnt[cur.client] ||
                        lcd_reg_sel !== tb_reg_sel[cur.client] || lcd_mode !== tb_mode[cur.client] ||
                        lcd_db_sel !== tb_db_sel[cur.client]) begin
                        failures++;
                        $display("FAIL grant_desc: gnt=%b cnt=%0d rs=%b mode=%b db=%b, required gnt=%b cnt=%0d rs=%b mode=%b db=%b",
                                 gnt, lcd_cnt, lcd_reg_sel, lcd_mode, lcd_db_sel, exp_vec,
                                 tb_cnt[cur.client], tb_reg_sel[cur.client], tb_mode[cur.client], tb_db_sel[cur.client]);
                    end
                end
            end
            if (lcd_enable === 1'b1) begin
                en_seen++;
                last_en_cyc = cyc;
                assertions++;
                if (prev_en === 1'b1 || cyc - last_grant_cyc != 1) begin
                    failures++;
                    $display("FAIL enable_pulse: enable %0d cycles after grant (prev_en=%b), required 1 cycle, single pulse",
                             cyc - last_grant_cyc, prev_en);
                end
            end
            if (done !== '0) begin
                done_seen++;
                last_done_cyc = cyc;
                exp_vec = '0;
                if (cur_valid && !cur.tmo) exp_vec[cur.client] = 1'b1;
                assertions++;
                if (done !== exp_vec) begin
                    failures++;
                    $display("FAIL done_vec: done=%b, required %b", done, exp_vec);
                end
            end
            if (timeout_err === 1'b1) begin
                tmo_seen++;
                last_tmo_cyc = cyc;
                assertions++;
                if (!(cur_valid && cur.tmo)) begin
                    failures++;
                    $display("FAIL timeout_unexpected: timeout_err=1, required 0");
                end
            end
            prev_gnt = gnt;
            prev_en  = lcd_enable;
        end
    end

    task automatic wait_done(input int target, input bit drop_each, input string name);
        int n = 0;
        while (done_seen < target && n < 200) begin
            @(negedge clk);
            #2;
            if (drop_each) req = req & ~done;
            n++;
        end
        req = '0;
        assertions++;
        if (done_seen < target) begin
            failures++;
            $display("FAIL %s: %0d done pulses seen, required %0d within 200 cycles", name, done_seen, target);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        assertions++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: busy=%b, required 0 within 50 cycles", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        assertions++;
        if ({lcd_enable, gnt, done, timeout_err, busy, init_done, lcd_reg_sel, lcd_mode, lcd_db_sel, lcd_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: en=%b gnt=%b done=%b tmo=%b busy=%b init=%b desc=%b%b%b cnt=%0d, required all 0",
                     lcd_enable, gnt, done, timeout_err, busy, init_done, lcd_reg_sel, lcd_mode, lcd_db_sel, lcd_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_init_lockout();
        int bad = 0;
        req = 3'b110;
        repeat (20) begin
            @(negedge clk);
            assertions++;
            if (gnt !== '0 || busy !== 1'b0) begin
                failures++;
                bad++;
                if (bad < 4) $display("FAIL lockout: gnt=%b busy=%b, required gnt=000 busy=0", gnt, busy);
            end
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int base_done = done_seen;
        int base_tmo  = tmo_seen;
        int n = 0;
        fin_delay = -1;
        exp_q.push_back('{client: 0, tmo: 1'b1});
        req = 3'b001;
        while (tmo_seen == base_tmo && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        req = '0;
        assertions++;
        if (tmo_seen != base_tmo + 1 || last_tmo_cyc - last_en_cyc != T) begin
            failures++;
            $display("FAIL timeout_latency: %0d pulses, %0d cycles after enable, required 1 pulse %0d cycles after enable",
                     tmo_seen - base_tmo, last_tmo_cyc - last_en_cyc, T);
        end
        wait_idle("timeout");
        repeat (3) @(negedge clk);
        assertions++;
        if (done_seen != base_done || init_done !== 1'b0 || tmo_seen != base_tmo + 1) begin
            failures++;
            $display("FAIL timeout_after: done pulses=%0d init_done=%b tmo pulses=%0d, required 0, 0, 1",
                     done_seen - base_done, init_done, tmo_seen - base_tmo);
        end
    endtask

    task automatic test_init();
        int base_en = en_seen;
        fin_delay = 5;
        exp_q.push_back('{client: 0, tmo: 1'b0});
        req = 3'b001;
        wait_done(done_seen + 1, 1'b0, "init_done_wait");
        assertions++;
        if (last_done_cyc - last_en_cyc != 6 || en_seen != base_en + 1) begin
            failures++;
            $display("FAIL init_timing: done %0d cycles after enable, %0d enables, required 6 cycles, 1 enable",
                     last_done_cyc - last_en_cyc, en_seen - base_en);
        end
        @(negedge clk);
        assertions++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL init_sticky: init_done=%b, required 1", init_done);
        end
        wait_idle("init");
    endtask

    task automatic test_round_robin();
        int base_g = grant_seen;
        fin_delay = 2;
        exp_q.push_back('{client: 1, tmo: 1'b0});
        exp_q.push_back('{client: 2, tmo: 1'b0});
        exp_q.push_back('{client: 1, tmo: 1'b0});
        req = 3'b110;
        wait_done(done_seen + 3, 1'b0, "rr_done_wait");
        wait_idle("rr");
        repeat (3) @(negedge clk);
        assertions++;
        if (grant_seen != base_g + 3 || exp_q.size() != 0 || lcd_cnt !== tb_cnt[1] || lcd_reg_sel !== tb_reg_sel[1]) begin
            failures++;
            $display("FAIL rr_sequence: grants=%0d pending=%0d idle cnt=%0d rs=%b, required 3, 0, %0d, %b",
                     grant_seen - base_g, exp_q.size(), lcd_cnt, lcd_reg_sel, tb_cnt[1], tb_reg_sel[1]);
        end
    endtask

    task automatic test_priority();
        int base_g = grant_seen;
        fin_delay = 2;
        exp_q.push_back('{client: 0, tmo: 1'b0});
        exp_q.push_back('{client: 2, tmo: 1'b0});
        req = 3'b111;
        wait_done(done_seen + 2, 1'b1, "prio_done_wait");
        wait_idle("prio");
        repeat (3) @(negedge clk);
        assertions++;
        if (grant_seen != base_g + 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL prio_sequence: grants=%0d pending=%0d, required 2, 0", grant_seen - base_g, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int gaps_bad = 0;
        fin_delay = 0;
        grant_cyc_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back('{client: 1 + (i % 2), tmo: 1'b0});
        req = 3'b110;
        wait_done(done_seen + 4, 1'b0, "b2b_done_wait");
        wait_idle("b2b");
        assertions++;
        if (grant_cyc_q.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: %0d grants, required 4", grant_cyc_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                if (grant_cyc_q[i] - grant_cyc_q[i-1] != 4) gaps_bad++;
            end
            if (gaps_bad != 0) begin
                failures++;
                $display("FAIL b2b_spacing: gaps %0d %0d %0d, required 4 4 4", grant_cyc_q[1] - grant_cyc_q[0],
                         grant_cyc_q[2] - grant_cyc_q[1], grant_cyc_q[3] - grant_cyc_q[2]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int base_en = en_seen;
        int n = 0;
        int base_done;
        fin_delay = -1;
        exp_q.push_back('{client: 1, tmo: 1'b0});
        req = 3'b010;
        while (en_seen == base_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        assertions++;
        if (busy !== 1'b1 || gnt !== 3'b010) begin
            failures++;
            $display("FAIL mid_wait_state: busy=%b gnt=%b, required 1, 010", busy, gnt);
        end
        #3 rst_n = 1'b0;
        #1;
        assertions++;
        if ({lcd_enable, gnt, done, timeout_err, busy, init_done, lcd_reg_sel, lcd_mode, lcd_db_sel, lcd_cnt} !== '0) begin
            failures++;
            $display("FAIL async_reset: en=%b gnt=%b done=%b tmo=%b busy=%b init=%b desc=%b%b%b cnt=%0d, required all 0",
                     lcd_enable, gnt, done, timeout_err, busy, init_done, lcd_reg_sel, lcd_mode, lcd_db_sel, lcd_cnt);
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        base_done = done_seen;
        man_fin = 1'b1;
        @(negedge clk);
        man_fin = 1'b0;
        repeat (5) @(negedge clk);
        assertions++;
        if (done_seen != base_done || busy !== 1'b0 || gnt !== '0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL stale_finish: done pulses=%0d busy=%b gnt=%b init=%b, required 0, 0, 000, 0",
                     done_seen - base_done, busy, gnt, init_done);
        end
    endtask

    task automatic test_finish_wins();
        int base_tmo = tmo_seen;
        fin_delay = T - 1;
        exp_q.push_back('{client: 0, tmo: 1'b0});
        req = 3'b001;
        wait_done(done_seen + 1, 1'b0, "tie_done_wait");
        assertions++;
        if (last_done_cyc - last_en_cyc != T) begin
            failures++;
            $display("FAIL tie_timing: done %0d cycles after enable, required %0d", last_done_cyc - last_en_cyc, T);
        end
        @(negedge clk);
        repeat (3) @(negedge clk);
        assertions++;
        if (tmo_seen != base_tmo || init_done !== 1'b1) begin
            failures++;
            $display("FAIL tie_result: tmo pulses=%0d init_done=%b, required 0, 1", tmo_seen - base_tmo, init_done);
        end
        wait_idle("tie");
    endtask

    initial begin
        req         = '0;
        req_reg_sel = {tb_reg_sel[2], tb_reg_sel[1], tb_reg_sel[0]};
        req_mode    = {tb_mode[2], tb_mode[1], tb_mode[0]};
        req_db_sel  = {tb_db_sel[2], tb_db_sel[1], tb_db_sel[0]};
        req_cnt     = {tb_cnt[2], tb_cnt[1], tb_cnt[0]};
        test_reset();
        test_init_lockout();
        test_timeout();
        test_init();
        test_round_robin();
        test_priority();
        test_back_to_back();
        test_reset_mid_wait();
        test_finish_wins();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion before 200000 time units");
        $fatal(1, "global timeout");
    end

endmodule
